coin_input_conditioner: RTL

Front-end stage of the vending datapath, directly upstream of `fsm_sell`. It turns the two raw, asynchronous, bouncy coin-sensor levels into clean single-cycle coin pulses on `a_point5` (0.5) and `b_1` (1.0). Guarantees for `fsm_sell`:
- exactly one pulse per physical coin;
- never both outputs in the same cycle;
- a minimum idle gap between pulses;
- coins are queued while the seller requests a hold.

---
 rtl/coin_pkg.sv | 13 +
 rtl/coin_debounce.sv | 44 ++++
 rtl/coin_input_conditioner.sv | 79 +++++++
 3 files changed

// File: rtl/coin_pkg.sv
// Shared types and defaults for the coin front-end.
package coin_pkg;
  typedef enum logic {COIN_HALF = 1'b0, COIN_ONE = 1'b1} coin_e;

  localparam int COIN_DEBOUNCE_DEF = 4;
  localparam int COIN_GAP_DEF      = 1;
  localparam int COIN_QDEPTH_DEF   = 4;

  // Bits needed for a counter spanning 0..n-1 (never below one bit).
  function automatic int cw(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/coin_debounce.sv
// One sensor channel: 2-flop sync, stability filter, arming, registered rise pulse.
module coin_debounce
  import coin_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = COIN_DEBOUNCE_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic rise
);
  localparam int CW = cw(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt, arm_cnt;
  logic          filt, armed;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync    <= '0;
      cnt     <= '0;
      arm_cnt <= '0;
      filt    <= 1'b0;
      armed   <= 1'b0;
      rise    <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      rise <= 1'b0;
      if (sync[1] == filt) cnt <= '0;
      else if (cnt == LAST) begin
        filt <= sync[1];
        cnt  <= '0;
        rise <= sync[1] & armed;
      end else cnt <= cnt + 1'b1;
      // A level held high through reset must go low once before it can count.
      if (!armed) begin
        if (sync[1]) arm_cnt <= '0;
        else if (arm_cnt == LAST) armed <= 1'b1;
        else arm_cnt <= arm_cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/coin_input_conditioner.sv
// Two debounced coin channels feeding a small FIFO and a gap-spaced pulse emitter.
module coin_input_conditioner
  import coin_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = COIN_DEBOUNCE_DEF,
  parameter int GAP_CYCLES      = COIN_GAP_DEF,
  parameter int QDEPTH          = COIN_QDEPTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          coin_half_raw,
  input  logic                          coin_one_raw,
  input  logic                          hold,
  output logic                          a_point5,
  output logic                          b_1,
  output logic [$clog2(QDEPTH+1)-1:0]   pending,
  output logic                          overflow
);
  localparam int PW   = $clog2(QDEPTH);
  localparam int CNTW = $clog2(QDEPTH + 1);
  localparam int GW   = cw(GAP_CYCLES + 1);

  logic [1:0] raw_vec, rise;
  assign raw_vec = {coin_one_raw, coin_half_raw};

  for (genvar c = 0; c < 2; c++) begin : g_ch
    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk  (clk),
      .rst  (rst),
      .raw  (raw_vec[c]),
      .rise (rise[c])
    );
  end

  coin_e           mem [QDEPTH];
  logic [PW-1:0]   wptr, rptr, wr2;
  logic [CNTW-1:0] count;
  logic [GW-1:0]   gap;
  logic [CNTW:0]   free;
  logic            pop, push_half, push_one;

  // Pop is decided first so its slot is already free for this cycle's pushes.
  always_comb begin
    pop       = (count != '0) && !hold && (gap == '0);
    free      = (CNTW+1)'(QDEPTH) - {1'b0, count} + {{CNTW{1'b0}}, pop};
    push_half = rise[COIN_HALF] && (free != '0);
    push_one  = rise[COIN_ONE] && (free > {{CNTW{1'b0}}, push_half});
    wr2       = wptr + PW'(push_half);
  end

  always_ff @(posedge clk) begin
    if (push_half) mem[wptr] <= COIN_HALF;
    if (push_one)  mem[wr2]  <= COIN_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      gap      <= '0;
      a_point5 <= 1'b0;
      b_1      <= 1'b0;
      overflow <= 1'b0;
    end else begin
      a_point5 <= pop && (mem[rptr] == COIN_HALF);
      b_1      <= pop && (mem[rptr] == COIN_ONE);
      overflow <= (rise[COIN_HALF] && !push_half) || (rise[COIN_ONE] && !push_one);
      if (pop) begin
        rptr <= rptr + 1'b1;
        gap  <= GW'(GAP_CYCLES);
      end else if (gap != '0) gap <= gap - 1'b1;
      wptr  <= wr2 + PW'(push_one);
      count <= count + CNTW'(push_half) + CNTW'(push_one) - CNTW'(pop);
    end
  end

  assign pending = count;
endmodule
